sync_fifo_mem: RTL and testbench

Parametrised single-clock FIFO built on the team's register-array memory.
- Generalises the plain write-port/read-port memory: adds pointer management, occupancy counting, full/empty/almost flags, a registered read with valid strobe, and error pulses.
- Sits between a producer and a consumer in the same clock domain; this is the standard buffering primitive for datapath blocks.

---
 rtl/memr_pkg.sv | 12 +
 rtl/mem_array_1clk.sv | 36 +++
 rtl/sync_fifo_mem.sv | 95 +++++++++
 tb/tb_sync_fifo_mem.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/memr_pkg.sv
// Shared constants and helpers for the register-array memory family.
// Depth is derived from the address width with a shift, so clog2 is not needed.
package memr_pkg;

   localparam int MEMR_D_WIDTH   = 32;
   localparam int MEMR_ADR_WIDTH = 5;

   function automatic int depth_of(input int adr_width);
      return 1 << adr_width;
   endfunction

endpackage

// File: rtl/mem_array_1clk.sv
// Single-clock register array with one write port and one registered read port.
// Storage is not reset. Only the read register is reset.
module mem_array_1clk
   import memr_pkg::*;
#(
   parameter int D_WIDTH   = MEMR_D_WIDTH,
   parameter int ADR_WIDTH = MEMR_ADR_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [ADR_WIDTH-1:0] wa,
   input  logic [D_WIDTH-1:0]   wd,
   input  logic                 re,
   input  logic [ADR_WIDTH-1:0] ra,
   output logic [D_WIDTH-1:0]   rd
);

   localparam int DEPTH = depth_of(ADR_WIDTH);

   logic [D_WIDTH-1:0] r_mem [DEPTH];
   logic [D_WIDTH-1:0] r_rd;

   always_ff @(posedge clk) begin
      if (we) r_mem[wa] <= wd;
   end

   // Non-blocking read of the same array gives old data on a same-address write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     r_rd <= '0;
      else if (re) r_rd <= r_mem[ra];
   end

   assign rd = r_rd;

endmodule

// File: rtl/sync_fifo_mem.sv
// Single-clock FIFO over mem_array_1clk: pointers, occupancy, flags, error pulses.
// A full FIFO accepts a write only when a read frees the slot in the same cycle.
module sync_fifo_mem
   import memr_pkg::*;
#(
   parameter int D_WIDTH   = MEMR_D_WIDTH,
   parameter int ADR_WIDTH = MEMR_ADR_WIDTH,
   parameter int AF_LEVEL  = 28,
   parameter int AE_LEVEL  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [D_WIDTH-1:0]   wr_data,
   input  logic                 rd_en,
   output logic [D_WIDTH-1:0]   rd_data,
   output logic                 rd_valid,
   output logic                 full,
   output logic                 empty,
   output logic                 almost_full,
   output logic                 almost_empty,
   output logic [ADR_WIDTH:0]   count,
   output logic                 wr_err,
   output logic                 rd_err
);

   localparam int DEPTH = depth_of(ADR_WIDTH);
   localparam int CNT_W = ADR_WIDTH + 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);
   localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_LEVEL);

   logic [ADR_WIDTH-1:0] r_wr_ptr;
   logic [ADR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_W-1:0]     r_count;
   logic                 r_rd_valid;
   logic                 r_wr_err;
   logic                 r_rd_err;

   logic w_full;
   logic w_empty;
   logic w_rd_acc;
   logic w_wr_acc;

   assign w_full   = (r_count == C_DEPTH);
   assign w_empty  = (r_count == '0);
   assign w_rd_acc = rd_en && !w_empty;
   assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

   mem_array_1clk #(
      .D_WIDTH   (D_WIDTH),
      .ADR_WIDTH (ADR_WIDTH)
   ) u_mem (
      .clk (clk),
      .rst (rst),
      .we  (w_wr_acc),
      .wa  (r_wr_ptr),
      .wd  (wr_data),
      .re  (w_rd_acc),
      .ra  (r_rd_ptr),
      .rd  (rd_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_rd_valid <= 1'b0;
         r_wr_err   <= 1'b0;
         r_rd_err   <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         r_rd_valid <= w_rd_acc;
         r_wr_err   <= wr_en && w_full && !w_rd_acc;
         r_rd_err   <= rd_en && w_empty;
      end
   end

   assign count        = r_count;
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= C_AF);
   assign almost_empty = (r_count <= C_AE);
   assign rd_valid     = r_rd_valid;
   assign wr_err       = r_wr_err;
   assign rd_err       = r_rd_err;

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Directed bench for sync_fifo_mem with immediate-assertion checks.
// Inputs change just after each rising edge; outputs are sampled there too.
module tb_sync_fifo_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = '0;
   logic        rd_en = 1'b0;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        full;
   logic        empty;
   logic        almost_full;
   logic        almost_empty;
   logic [5:0]  count;
   logic        wr_err;
   logic        rd_err;

   int n_tests = 0;
   int n_fail  = 0;

   sync_fifo_mem dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .wr_err       (wr_err),
      .rd_err       (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int base, input int n, input int start_cnt);
      for (int i = 0; i < n; i++) begin
         wr_en   = 1'b1;
         wr_data = 32'(base + i);
         step();
         chk("fill_count", 64'(count), 64'(start_cnt + i + 1));
         chk("fill_af", 64'(almost_full), 64'(start_cnt + i + 1 >= 28));
         chk("fill_ae", 64'(almost_empty), 64'(start_cnt + i + 1 <= 4));
      end
      wr_en = 1'b0;
   endtask

   task automatic drain(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         rd_en = 1'b1;
         step();
         chk("drain_data", 64'(rd_data), 64'(base + i));
         chk("drain_valid", 64'(rd_valid), 64'd1);
      end
      rd_en = 1'b0;
   endtask

   initial begin
      // Reset asserted mid-cycle must act with no clock edge
      #3 rst = 1'b1;
      #1;
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_rd_valid", 64'(rd_valid), 64'd0);
      chk("rst_af", 64'(almost_full), 64'd0);
      chk("rst_ae", 64'(almost_empty), 64'd1);
      chk("rst_errs", 64'({wr_err, rd_err}), 64'd0);
      step();
      rst = 1'b0;
      step();

      // Single word
      wr_en   = 1'b1;
      wr_data = 32'hC5;
      step();
      wr_en = 1'b0;
      chk("sw_count1", 64'(count), 64'd1);
      chk("sw_not_empty", 64'(empty), 64'd0);
      chk("sw_no_valid", 64'(rd_valid), 64'd0);
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("sw_data", 64'(rd_data), 64'hC5);
      chk("sw_valid", 64'(rd_valid), 64'd1);
      chk("sw_count0", 64'(count), 64'd0);
      chk("sw_empty", 64'(empty), 64'd1);
      step();
      chk("sw_valid_drop", 64'(rd_valid), 64'd0);
      chk("sw_data_hold", 64'(rd_data), 64'hC5);

      // Fill from pointer 1 so the pass wraps the pointers
      fill(0, 32, 0);
      chk("fill_full", 64'(full), 64'd1);
      wr_en   = 1'b1;
      wr_data = 32'hEE;
      step();
      wr_en = 1'b0;
      chk("ovf_wr_err", 64'(wr_err), 64'd1);
      chk("ovf_count", 64'(count), 64'd32);
      step();
      chk("ovf_err_drop", 64'(wr_err), 64'd0);
      drain(0, 32);
      chk("drain_empty", 64'(empty), 64'd1);
      chk("drain_count", 64'(count), 64'd0);

      fill(100, 32, 0);
      drain(100, 32);
      chk("wrap_empty", 64'(empty), 64'd1);

      // Full with simultaneous read and write
      fill(200, 32, 0);
      wr_en   = 1'b1;
      wr_data = 32'hD5;
      rd_en   = 1'b1;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("fullrw_count", 64'(count), 64'd32);
      chk("fullrw_data", 64'(rd_data), 64'd200);
      chk("fullrw_valid", 64'(rd_valid), 64'd1);
      chk("fullrw_wr_err", 64'(wr_err), 64'd0);
      drain(201, 31);
      drain(32'hD5, 1);
      chk("fullrw_empty", 64'(empty), 64'd1);

      // Empty with simultaneous read and write
      wr_en   = 1'b1;
      wr_data = 32'h1A;
      rd_en   = 1'b1;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("emptyrw_rd_err", 64'(rd_err), 64'd1);
      chk("emptyrw_valid", 64'(rd_valid), 64'd0);
      chk("emptyrw_count", 64'(count), 64'd1);
      step();
      chk("emptyrw_err_drop", 64'(rd_err), 64'd0);
      drain(32'h1A, 1);
      chk("emptyrw_empty", 64'(empty), 64'd1);

      // Reset mid-traffic discards stored words
      fill(300, 10, 0);
      #2 rst = 1'b1;
      #1;
      chk("mrst_count", 64'(count), 64'd0);
      chk("mrst_empty", 64'(empty), 64'd1);
      chk("mrst_rd_data", 64'(rd_data), 64'd0);
      step();
      rst = 1'b0;
      step();
      wr_en   = 1'b1;
      wr_data = 32'h1B;
      step();
      wr_en = 1'b0;
      drain(32'h1B, 1);
      chk("mrst_empty2", 64'(empty), 64'd1);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("mrst_no_stale_valid", 64'(rd_valid), 64'd0);
      chk("mrst_no_stale_err", 64'(rd_err), 64'd1);
      chk("mrst_data_hold", 64'(rd_data), 64'h1B);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
